sample_strobe_gen: RTL and testbench

//  Parametrised ADC sample-strobe generator; successor to the fixed 32-bit divider.

---
 rtl/sample_strobe_gen_pkg.sv | 18 +
 rtl/sample_strobe_gen_tc_counter.sv | 33 +++
 rtl/sample_strobe_gen.sv | 163 ++++++++++++++++
 tb/tb_sample_strobe_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_strobe_gen_pkg.sv
// Shared state encoding, mode values and default widths for the ADC sample-strobe generator.
package sample_strobe_gen_pkg;

  localparam int DEF_DIV_W = 32;
  localparam int DEF_DLY_W = 32;
  localparam int DEF_CNT_W = 16;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sample_strobe_gen_tc_counter.sv
// Up-counter with synchronous clear and enable; tc_o flags the cycle where the count
// equals tc_val_i, and the count wraps to zero on that cycle.
module tc_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic         at_tc;

  assign at_tc = (cnt_q == tc_val_i);

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (at_tc) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + W'(1);
      end
    end
  end

  assign tc_o = en_i && at_tc;

endmodule

// File: rtl/sample_strobe_gen.sv
// ADC sample-strobe generator: continuous divider or delayed fixed-length burst,
// with done/abort status pulses. All outputs are registered.
module sample_strobe_gen
  import sample_strobe_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int DLY_W = DEF_DLY_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ad_sample_en,
  input  logic             mode,
  input  logic             start,
  input  logic [DIV_W-1:0] div_set,
  input  logic [DLY_W-1:0] dly_set,
  input  logic [CNT_W-1:0] point_set,
  output logic             adc_data_en,
  output logic [CNT_W-1:0] sample_idx,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  state_e           state_q;
  logic             mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DLY_W-1:0] dly_q;
  logic [CNT_W-1:0] point_q;
  logic [CNT_W-1:0] nxt_idx_q;

  logic             adc_data_en_q;
  logic [CNT_W-1:0] sample_idx_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;

  logic             div_tc;
  logic             dly_tc;
  logic [DLY_W-1:0] dly_tc_val;
  logic             last_pt;
  logic             run_req;

  // DELAY is only entered with dly_q > 0, so dly_q-1 never underflows while it is in use
  assign dly_tc_val = dly_q - DLY_W'(1);
  assign last_pt    = (nxt_idx_q == point_q - CNT_W'(1));
  assign run_req    = ad_sample_en && ((mode == MODE_CONT) || start);

  tc_counter #(.W(DLY_W)) u_dly_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q != ST_DELAY),
    .en_i     (state_q == ST_DELAY),
    .tc_val_i (dly_tc_val),
    .tc_o     (dly_tc)
  );

  tc_counter #(.W(DIV_W)) u_div_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q != ST_RUN),
    .en_i     (state_q == ST_RUN),
    .tc_val_i (div_q),
    .tc_o     (div_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_CONT;
      div_q         <= '0;
      dly_q         <= '0;
      point_q       <= '0;
      nxt_idx_q     <= '0;
      adc_data_en_q <= 1'b0;
      sample_idx_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      adc_data_en_q <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          nxt_idx_q <= '0;
          // configuration is captured only here so live edits never disturb a run
          if (run_req) begin
            mode_q  <= mode;
            div_q   <= div_set;
            dly_q   <= dly_set;
            point_q <= point_set;
            busy_q  <= 1'b1;
            if (mode == MODE_BURST && dly_set != '0) begin
              state_q <= ST_DELAY;
            end else if (mode == MODE_BURST && point_set == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end

        ST_DELAY: begin
          if (!ad_sample_en) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            aborted_q    <= 1'b1;
            nxt_idx_q    <= '0;
            sample_idx_q <= '0;
          end else if (dly_tc) begin
            if (point_q == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          // abort wins over a strobe falling due in the same cycle
          if (!ad_sample_en) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            aborted_q    <= 1'b1;
            nxt_idx_q    <= '0;
            sample_idx_q <= '0;
          end else if (div_tc) begin
            adc_data_en_q <= 1'b1;
            sample_idx_q  <= nxt_idx_q;
            nxt_idx_q     <= nxt_idx_q + CNT_W'(1);
            if (mode_q == MODE_BURST && last_pt) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          nxt_idx_q    <= '0;
          sample_idx_q <= '0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_data_en = adc_data_en_q;
  assign sample_idx  = sample_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_sample_strobe_gen.sv
// Directed bench for sample_strobe_gen: a per-cycle vector table plus hand-written
// multi-cycle sequences for the continuous, long-delay, reset and reconfiguration cases.
module tb_sample_strobe_gen;

  localparam int DIV_W = 32;
  localparam int DLY_W = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             ad_sample_en;
  logic             mode;
  logic             start;
  logic [DIV_W-1:0] div_set;
  logic [DLY_W-1:0] dly_set;
  logic [CNT_W-1:0] point_set;
  logic             adc_data_en;
  logic [CNT_W-1:0] sample_idx;
  logic             busy;
  logic             done;
  logic             aborted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic        md;
    logic        st;
    int          div;
    int          dly;
    int          pts;
    logic        xEn;
    logic [15:0] xIdx;
    logic        xBusy;
    logic        xDone;
    logic        xAbort;
  } vec_t;

  vec_t vq[$];

  sample_strobe_gen #(.DIV_W(DIV_W), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ad_sample_en (ad_sample_en),
    .mode         (mode),
    .start        (start),
    .div_set      (div_set),
    .dly_set      (dly_set),
    .point_set    (point_set),
    .adc_data_en  (adc_data_en),
    .sample_idx   (sample_idx),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic en, input logic md, input logic st,
                               input int div, input int dly, input int pts);
    reset        = rst;
    ad_sample_en = en;
    mode         = md;
    start        = st;
    div_set      = DIV_W'(div);
    dly_set      = DLY_W'(dly);
    point_set    = CNT_W'(pts);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // sample_idx is only meaningful alongside a strobe, so it is compared only then
  task automatic checkOutput(input string name, input logic xEn, input logic [15:0] xIdx,
                             input logic xBusy, input logic xDone, input logic xAbort);
    logic ok;
    checks++;
    ok = (adc_data_en === xEn) && (busy === xBusy) && (done === xDone) && (aborted === xAbort);
    if (xEn && sample_idx !== CNT_W'(xIdx)) ok = 1'b0;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got en=%b idx=%0d busy=%b done=%b abort=%b, want en=%b idx=%0d busy=%b done=%b abort=%b",
               name, $time, adc_data_en, sample_idx, busy, done, aborted,
               xEn, xIdx, xBusy, xDone, xAbort);
    end
  endtask

  task automatic addVec(input logic rst, input logic en, input logic md, input logic st,
                        input int div, input int dly, input int pts,
                        input logic xEn, input int xIdx, input logic xBusy,
                        input logic xDone, input logic xAbort);
    vec_t v;
    v.rst = rst; v.en = en; v.md = md; v.st = st;
    v.div = div; v.dly = dly; v.pts = pts;
    v.xEn = xEn; v.xIdx = 16'(xIdx); v.xBusy = xBusy; v.xDone = xDone; v.xAbort = xAbort;
    vq.push_back(v);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Each row: inputs held for one cycle, expected outputs seen after the next edge.
    addVec(1, 0, 1, 0, 0, 0, 5,   0, 0, 0, 0, 0);  // reset state
    // burst div=0 dly=0 pts=5, start at T
    addVec(0, 1, 1, 1, 0, 0, 5,   0, 0, 1, 0, 0);  // T+1 RUN
    addVec(0, 1, 1, 0, 0, 0, 5,   1, 0, 1, 0, 0);  // T+2
    addVec(0, 1, 1, 0, 0, 0, 5,   1, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0, 0, 5,   1, 2, 1, 0, 0);
    addVec(0, 1, 1, 0, 0, 0, 5,   1, 3, 1, 0, 0);
    addVec(0, 1, 1, 0, 0, 0, 5,   1, 4, 1, 1, 0);  // T+6 last strobe + done
    addVec(0, 1, 1, 1, 0, 4, 0,   0, 0, 0, 0, 0);  // start during DONE ignored, T+7 idle
    // burst pts=0 dly=4, start at S in the first idle cycle after done
    addVec(0, 1, 1, 1, 0, 4, 0,   0, 0, 1, 0, 0);  // S+1
    addVec(0, 1, 1, 0, 0, 4, 0,   0, 0, 1, 0, 0);
    addVec(0, 1, 1, 0, 0, 4, 0,   0, 0, 1, 0, 0);
    addVec(0, 1, 1, 1, 0, 4, 0,   0, 0, 1, 0, 0);  // start while busy ignored
    addVec(0, 1, 1, 0, 0, 4, 0,   0, 0, 1, 1, 0);  // S+5 done, no strobe
    addVec(0, 1, 1, 0, 0, 4, 0,   0, 0, 0, 0, 0);  // S+6 idle
    // burst div=2 pts=4, abort one cycle before the 2nd strobe
    addVec(0, 1, 1, 1, 2, 0, 4,   0, 0, 1, 0, 0);  // U+1 RUN
    addVec(0, 1, 1, 0, 2, 0, 4,   0, 0, 1, 0, 0);
    addVec(0, 1, 1, 0, 2, 0, 4,   0, 0, 1, 0, 0);
    addVec(0, 1, 1, 0, 2, 0, 4,   1, 0, 1, 0, 0);  // U+4 first strobe
    addVec(0, 1, 1, 0, 2, 0, 4,   0, 0, 1, 0, 0);
    addVec(0, 1, 1, 0, 2, 0, 4,   0, 0, 1, 0, 0);
    addVec(0, 0, 1, 0, 2, 0, 4,   0, 0, 0, 0, 1);  // U+7 strobe suppressed, aborted
    addVec(0, 0, 1, 0, 2, 0, 4,   0, 0, 0, 0, 0);
    // restart after abort, index restarts at 0
    addVec(0, 1, 1, 1, 2, 0, 4,   0, 0, 1, 0, 0);
    addVec(0, 1, 1, 0, 2, 0, 4,   0, 0, 1, 0, 0);
    addVec(0, 1, 1, 0, 2, 0, 4,   0, 0, 1, 0, 0);
    addVec(0, 1, 1, 0, 2, 0, 4,   1, 0, 1, 0, 0);
    addVec(0, 0, 1, 0, 2, 0, 4,   0, 0, 0, 0, 1);
    addVec(0, 0, 1, 0, 2, 0, 4,   0, 0, 0, 0, 0);
    // pts=0, dly=0: straight to DONE
    addVec(0, 1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 0);
    addVec(0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      applyStimulus(vq[i].rst, vq[i].en, vq[i].md, vq[i].st, vq[i].div, vq[i].dly, vq[i].pts);
      stepCycle();
      checkOutput($sformatf("vec%0d", i), vq[i].xEn, vq[i].xIdx, vq[i].xBusy, vq[i].xDone, vq[i].xAbort);
    end

    // Continuous, div=3: RUN entry E, strobes at E+4k, idx k-1, then abort on a due strobe
    applyStimulus(0, 1, 0, 0, 3, 0, 0);
    stepCycle();
    checkOutput("cont_entry", 0, 0, 1, 0, 0);
    for (int k = 1; k <= 23; k++) begin
      stepCycle();
      checkOutput($sformatf("cont_k%0d", k), (k % 4) == 0, 16'((k / 4) - 1), 1, 0, 0);
    end
    ad_sample_en = 1'b0;
    stepCycle();
    checkOutput("cont_abort", 0, 0, 0, 0, 1);
    stepCycle();
    checkOutput("cont_idle", 0, 0, 0, 0, 0);

    // Burst div=2 dly=10 pts=3: RUN at T+11, strobes T+14/17/20, done T+20
    applyStimulus(0, 1, 1, 1, 2, 10, 3);
    for (int k = 1; k <= 21; k++) begin
      stepCycle();
      start = 1'b0;
      checkOutput($sformatf("dly_k%0d", k), (k == 14) || (k == 17) || (k == 20),
                  16'((k - 14) / 3), k <= 20, k == 20, 0);
    end

    // Reset together with start in the middle of a run
    applyStimulus(0, 1, 1, 1, 5, 0, 10);
    stepCycle();
    start = 1'b0;
    for (int k = 0; k < 3; k++) stepCycle();
    applyStimulus(1, 1, 1, 1, 5, 0, 10);
    stepCycle();
    checkOutput("rst_midrun", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 5, 0, 10);
    stepCycle();
    checkOutput("rst_release", 0, 0, 0, 0, 0);

    // div_set edited mid-run: old period (2) kept; the next run picks up 8
    applyStimulus(0, 1, 1, 1, 1, 0, 3);
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      start   = 1'b0;
      div_set = DIV_W'(7);
      checkOutput($sformatf("shadow_k%0d", k), (k == 3) || (k == 5) || (k == 7),
                  16'((k - 3) / 2), k <= 7, k == 7, 0);
    end
    applyStimulus(0, 1, 1, 1, 7, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      stepCycle();
      start = 1'b0;
      checkOutput($sformatf("newdiv_k%0d", k), k == 9, 0, k <= 9, k == 9, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
